fetch_realign_fifo: RTL and testbench

- Sits between the instruction-fetch interface and decode in the 32-bit C-extension core.
- Accepts 32-bit fetch beats of 2 halfwords each and stores them as a halfword FIFO.
- Emits one whole instruction per cycle: a 16-bit compressed or a 32-bit uncompressed instruction, including 32-bit instructions that straddle two beats.
- Tracks the PC of every emitted instruction and propagates fetch faults.

---
 rtl/fetch_realign_fifo_pkg.sv | 14 +
 rtl/fetch_realign_decode.sv | 54 +++++
 rtl/fetch_realign_fifo.sv | 160 ++++++++++++++++
 tb/tb_fetch_realign_fifo.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_realign_fifo_pkg.sv
// Shared types and constants for the fetch realignment FIFO.
// The halfword entry carries a fault bit used only when FETCH_REALIGN_EXC_EN is defined.
package fetch_realign_fifo_pkg;

  localparam int unsigned XLEN               = 32;
  localparam int unsigned HWORD_W            = 16;
  localparam logic [1:0]  COMPRESSED_OP_MASK = 2'b11;

  typedef struct packed {
    logic [HWORD_W-1:0] data;
    logic               fault;
  } hword_t;

endpackage

// File: rtl/fetch_realign_decode.sv
// Combinational decode of the two oldest FIFO halfwords into one instruction.
// Produces the valid flag, the instruction, the pop count and the PC increment.
module fetch_realign_decode
  import fetch_realign_fifo_pkg::*;
(
  input  hword_t          head_i,
  input  hword_t          second_i,
  input  logic            head_avail_i,
  input  logic            second_avail_i,
  output logic            valid_o,
  output logic            compressed_o,
  output logic            ex_o,
  output logic [1:0]      pop_cnt_o,
  output logic [2:0]      pc_inc_o,
  output logic [XLEN-1:0] instr_o
);

  logic head_compressed;

  assign head_compressed = (head_i.data[1:0] & COMPRESSED_OP_MASK) != COMPRESSED_OP_MASK;

  always_comb begin
    valid_o      = 1'b0;
    compressed_o = 1'b0;
    ex_o         = 1'b0;
    pop_cnt_o    = 2'd0;
    pc_inc_o     = 3'd0;
    instr_o      = '0;
    if (head_avail_i) begin
      if (head_i.fault) begin
        valid_o   = 1'b1;
        ex_o      = 1'b1;
        pop_cnt_o = 2'd1;
      end else if (head_compressed) begin
        valid_o      = 1'b1;
        compressed_o = 1'b1;
        pop_cnt_o    = 2'd1;
        pc_inc_o     = 3'd2;
        instr_o      = {{(XLEN-HWORD_W){1'b0}}, head_i.data};
      end else if (second_avail_i) begin
        // A faulting upper half poisons the whole 32-bit instruction at the head PC.
        valid_o   = 1'b1;
        pop_cnt_o = 2'd2;
        if (second_i.fault) begin
          ex_o = 1'b1;
        end else begin
          pc_inc_o = 3'd4;
          instr_o  = {second_i.data, head_i.data};
        end
      end
    end
  end

endmodule

// File: rtl/fetch_realign_fifo.sv
// Halfword FIFO between fetch and decode that realigns compressed/uncompressed instructions.
// Define FETCH_REALIGN_EXC_EN to store per-entry fetch faults and drive ex_o.
module fetch_realign_fifo
  import fetch_realign_fifo_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            fetch_valid_i,
  output logic            fetch_ready_o,
  input  logic [XLEN-1:0] fetch_data_i,
  input  logic [XLEN-1:0] fetch_addr_i,
  input  logic            fetch_ex_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            is_compressed_o,
  output logic            ex_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [HWORD_W-1:0] data_q [Depth];
  logic [CntW-1:0]    count_q, count_d;
  logic [PtrW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [PtrW-1:0]    head_p1, head_p2, tail_p1, tail_p2;
  logic [XLEN-1:0]    pc_q, pc_d;

  logic               fetch_fire, pop;
  logic [1:0]         push_cnt, pop_cnt;
  logic [HWORD_W-1:0] wr0_data, wr1_data;
  logic               wr0_fault;
  hword_t             head_e, second_e;

  logic               dec_valid, dec_compressed, dec_ex;
  logic [1:0]         dec_pop_cnt;
  logic [2:0]         dec_pc_inc;
  logic [XLEN-1:0]    dec_instr;

  function automatic logic [PtrW-1:0] ptr_add(input logic [PtrW-1:0] p, input logic [1:0] n);
    logic [PtrW:0] s;
    s = {1'b0, p} + {{(PtrW-1){1'b0}}, n};
    if (s >= (PtrW+1)'(Depth)) s = s - (PtrW+1)'(Depth);
    return s[PtrW-1:0];
  endfunction

  assign head_p1 = ptr_add(head_q, 2'd1);
  assign head_p2 = ptr_add(head_q, 2'd2);
  assign tail_p1 = ptr_add(tail_q, 2'd1);
  assign tail_p2 = ptr_add(tail_q, 2'd2);

  // Space is judged on the start-of-cycle count; a same-cycle pop is not credited.
  assign fetch_ready_o = !rst_i && !flush_i && (count_q <= CntW'(Depth - 2));
  assign fetch_fire    = fetch_valid_i && fetch_ready_o;

`ifdef FETCH_REALIGN_EXC_EN
  logic fault_q [Depth];
  logic unused_addr;
  assign unused_addr = fetch_addr_i[0];
  assign head_e      = '{data: data_q[head_q], fault: fault_q[head_q]};
  assign second_e    = '{data: data_q[head_p1], fault: fault_q[head_p1]};
  assign ex_o        = !rst_i && dec_ex;

  always_ff @(posedge clk_i) begin
    if (push_cnt != 2'd0) fault_q[tail_q] <= wr0_fault;
    if (push_cnt == 2'd2) fault_q[tail_p1] <= 1'b0;
  end
`else
  logic unused_ex;
  assign unused_ex = ^{fetch_ex_i, fetch_addr_i[0], dec_ex, wr0_fault};
  assign head_e    = '{data: data_q[head_q], fault: 1'b0};
  assign second_e  = '{data: data_q[head_p1], fault: 1'b0};
  assign ex_o      = 1'b0;
`endif

  always_comb begin
    push_cnt  = 2'd0;
    wr0_data  = fetch_data_i[HWORD_W-1:0];
    wr1_data  = fetch_data_i[XLEN-1:HWORD_W];
    wr0_fault = 1'b0;
    if (fetch_fire) begin
`ifdef FETCH_REALIGN_EXC_EN
      if (fetch_ex_i) begin
        push_cnt  = 2'd1;
        wr0_data  = '0;
        wr0_fault = 1'b1;
      end else
`endif
      if (fetch_addr_i[1]) begin
        push_cnt = 2'd1;
        wr0_data = fetch_data_i[XLEN-1:HWORD_W];
      end else begin
        push_cnt = 2'd2;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_cnt != 2'd0) data_q[tail_q] <= wr0_data;
    if (push_cnt == 2'd2) data_q[tail_p1] <= wr1_data;
  end

  fetch_realign_decode u_decode (
    .head_i        (head_e),
    .second_i      (second_e),
    .head_avail_i  (count_q != '0),
    .second_avail_i(count_q > CntW'(1)),
    .valid_o       (dec_valid),
    .compressed_o  (dec_compressed),
    .ex_o          (dec_ex),
    .pop_cnt_o     (dec_pop_cnt),
    .pc_inc_o      (dec_pc_inc),
    .instr_o       (dec_instr)
  );

  assign instr_valid_o   = !rst_i && dec_valid;
  assign is_compressed_o = !rst_i && dec_compressed;
  assign instr_o         = rst_i ? '0 : dec_instr;
  assign instr_pc_o      = rst_i ? '0 : pc_q;

  assign pop     = instr_valid_o && instr_ready_i && !flush_i;
  assign pop_cnt = pop ? dec_pop_cnt : 2'd0;

  always_comb begin
    count_d = count_q + CntW'(push_cnt) - CntW'(pop_cnt);
    head_d  = head_q;
    tail_d  = tail_q;
    pc_d    = pop ? pc_q + XLEN'(dec_pc_inc) : pc_q;
    if (pop_cnt == 2'd1) head_d = head_p1;
    if (pop_cnt == 2'd2) head_d = head_p2;
    if (push_cnt == 2'd1) tail_d = tail_p1;
    if (push_cnt == 2'd2) tail_d = tail_p2;
    // An empty FIFO means the beat starts a new stream: take its address as the PC.
    if (push_cnt != 2'd0 && count_q == '0) pc_d = {fetch_addr_i[XLEN-1:1], 1'b0};
    if (flush_i) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      pc_q    <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_realign_fifo.sv
// Directed self-checking bench for fetch_realign_fifo (Depth 8).
// Fault expectations follow FETCH_REALIGN_EXC_EN when the bench is built with it.
module tb_fetch_realign_fifo;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, fetch_valid_i, fetch_ready_o, fetch_ex_i;
  logic [31:0] fetch_data_i, fetch_addr_i;
  logic        instr_valid_o, instr_ready_i, is_compressed_o, ex_o;
  logic [31:0] instr_o, instr_pc_o;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk_i = ~clk_i;

  fetch_realign_fifo #(.Depth(8)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .fetch_valid_i  (fetch_valid_i),
    .fetch_ready_o  (fetch_ready_o),
    .fetch_data_i   (fetch_data_i),
    .fetch_addr_i   (fetch_addr_i),
    .fetch_ex_i     (fetch_ex_i),
    .instr_valid_o  (instr_valid_o),
    .instr_ready_i  (instr_ready_i),
    .instr_o        (instr_o),
    .instr_pc_o     (instr_pc_o),
    .is_compressed_o(is_compressed_o),
    .ex_o           (ex_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic beat(input logic [31:0] addr, input logic [31:0] data, input logic ex);
    fetch_valid_i = 1'b1;
    fetch_addr_i  = addr;
    fetch_data_i  = data;
    fetch_ex_i    = ex;
  endtask

  task automatic idle();
    fetch_valid_i = 1'b0;
    fetch_ex_i    = 1'b0;
    fetch_addr_i  = '0;
    fetch_data_i  = '0;
  endtask

  task automatic expect_instr(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                              input logic comp);
    check({tag, "_valid"}, instr_valid_o, 1'b1);
    check({tag, "_instr"}, instr_o, instr);
    check({tag, "_pc"}, instr_pc_o, pc);
    check({tag, "_comp"}, is_compressed_o, comp);
    check({tag, "_ex"}, ex_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] h [8];
    rst_i = 1'b1;
    flush_i = 1'b0;
    instr_ready_i = 1'b1;
    idle();
    settle();
    check("rst_ready", fetch_ready_o, 1'b0);
    tick();
    tick();
    rst_i = 1'b0;
    settle();
    check("rst_valid", instr_valid_o, 1'b0);
    check("rst_ready_rel", fetch_ready_o, 1'b1);
    check("rst_instr", instr_o, 32'h0);
    check("rst_pc", instr_pc_o, 32'h0);
    check("rst_comp", is_compressed_o, 1'b0);
    check("rst_ex", ex_o, 1'b0);

    // Two halfwords: 0x4501 is compressed, 0x00A3 has low bits 11 and must wait for more data.
    beat(32'h1000, 32'h00A3_4501, 1'b0);
    tick();
    idle();
    settle();
    expect_instr("c0", 32'h0000_4501, 32'h1000, 1'b1);
    tick();
    settle();
    check("c1_wait", instr_valid_o, 1'b0);
    beat(32'h1004, 32'h0000_0001, 1'b0);
    tick();
    idle();
    settle();
    expect_instr("c1_join", 32'h0001_00A3, 32'h1002, 1'b0);
    tick();
    settle();
    expect_instr("c2", 32'h0000_0000, 32'h1006, 1'b1);
    tick();
    settle();
    check("c_empty", instr_valid_o, 1'b0);

    // Straddle across beats
    beat(32'h2000, 32'h0513_4505, 1'b0);
    tick();
    idle();
    settle();
    expect_instr("s0", 32'h0000_4505, 32'h2000, 1'b1);
    tick();
    settle();
    check("s_wait", instr_valid_o, 1'b0);
    beat(32'h2004, 32'h0000_0085, 1'b0);
    tick();
    idle();
    settle();
    expect_instr("s1", 32'h0085_0513, 32'h2002, 1'b0);
    tick();
    settle();
    expect_instr("s2", 32'h0000_0000, 32'h2006, 1'b1);
    tick();
    settle();
    check("s_empty", instr_valid_o, 1'b0);

    // Halfword-aligned branch target: low half dropped
    beat(32'h3002, 32'h4581_BEEF, 1'b0);
    tick();
    idle();
    settle();
    expect_instr("br", 32'h0000_4581, 32'h3002, 1'b1);
    tick();
    settle();
    check("br_empty", instr_valid_o, 1'b0);

    // Backpressure: fill 8 halfwords, then drain in order
    for (int j = 0; j < 8; j++) h[j] = 16'h0101 + 16'(4 * j);
    instr_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      beat(32'h6000 + 32'(4 * k), {h[2*k+1], h[2*k]}, 1'b0);
      settle();
      check($sformatf("bp_rdy%0d", k), fetch_ready_o, 1'b1);
      tick();
    end
    beat(32'h6010, 32'h5555_5555, 1'b0);
    settle();
    check("bp_full", fetch_ready_o, 1'b0);
    expect_instr("bp_hold0", 32'h0000_0101, 32'h6000, 1'b1);
    tick();
    idle();
    settle();
    check("bp_full2", fetch_ready_o, 1'b0);
    expect_instr("bp_hold1", 32'h0000_0101, 32'h6000, 1'b1);
    instr_ready_i = 1'b1;
    for (int j = 0; j < 8; j++) begin
      settle();
      expect_instr($sformatf("bp_d%0d", j), {16'h0, h[j]}, 32'h6000 + 32'(2 * j), 1'b1);
      tick();
    end
    settle();
    check("bp_empty", instr_valid_o, 1'b0);

    // Fetch fault on the upper half of a straddling instruction
    beat(32'h3FFE, 32'h0513_BEEF, 1'b0);
    tick();
    idle();
    settle();
    check("f_wait", instr_valid_o, 1'b0);
    beat(32'h4000, 32'h1234_0085, 1'b1);
    tick();
    idle();
    settle();
`ifdef FETCH_REALIGN_EXC_EN
    check("f_valid", instr_valid_o, 1'b1);
    check("f_ex", ex_o, 1'b1);
    check("f_instr", instr_o, 32'h0);
    check("f_pc", instr_pc_o, 32'h3FFE);
    check("f_comp", is_compressed_o, 1'b0);
    tick();
    settle();
    check("f_empty", instr_valid_o, 1'b0);
    beat(32'h4004, 32'hFFFF_FFFF, 1'b1);
    tick();
    idle();
    settle();
    check("fh_valid", instr_valid_o, 1'b1);
    check("fh_ex", ex_o, 1'b1);
    check("fh_instr", instr_o, 32'h0);
    check("fh_pc", instr_pc_o, 32'h4004);
    tick();
    settle();
    check("fh_empty", instr_valid_o, 1'b0);
`else
    expect_instr("f_noexc", 32'h0085_0513, 32'h3FFE, 1'b0);
    tick();
    settle();
    expect_instr("f_noexc2", 32'h0000_1234, 32'h4002, 1'b1);
    tick();
    settle();
    check("f_empty", instr_valid_o, 1'b0);
`endif

    // Flush with a pending instruction and a valid beat
    instr_ready_i = 1'b0;
    beat(32'h7000, 32'h0005_0001, 1'b0);
    tick();
    idle();
    settle();
    expect_instr("fl_pend", 32'h0000_0001, 32'h7000, 1'b1);
    flush_i = 1'b1;
    beat(32'h7004, 32'h0009_000D, 1'b0);
    settle();
    check("fl_rdy", fetch_ready_o, 1'b0);
    tick();
    flush_i = 1'b0;
    idle();
    settle();
    check("fl_valid", instr_valid_o, 1'b0);
    check("fl_rdy_back", fetch_ready_o, 1'b1);
    instr_ready_i = 1'b1;
    beat(32'h5000, 32'h4581_4505, 1'b0);
    tick();
    idle();
    settle();
    expect_instr("fl_new0", 32'h0000_4505, 32'h5000, 1'b1);
    tick();
    settle();
    expect_instr("fl_new1", 32'h0000_4581, 32'h5002, 1'b1);
    tick();
    settle();
    check("fl_empty", instr_valid_o, 1'b0);

    // Reset mid-operation
    instr_ready_i = 1'b0;
    beat(32'h8000, 32'h0001_0001, 1'b0);
    tick();
    idle();
    settle();
    check("mr_pend", instr_valid_o, 1'b1);
    rst_i = 1'b1;
    settle();
    check("mr_valid_in", instr_valid_o, 1'b0);
    check("mr_rdy_in", fetch_ready_o, 1'b0);
    tick();
    rst_i = 1'b0;
    settle();
    check("mr_valid", instr_valid_o, 1'b0);
    check("mr_pc", instr_pc_o, 32'h0);
    check("mr_instr", instr_o, 32'h0);
    check("mr_rdy", fetch_ready_o, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
